// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: one outstanding imem read at a time, results
// buffered with their PCs in a small FIFO and handed to the core over
// valid/ready. A core redirect flushes the FIFO and squashes any in-flight read.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // DROP: a read is still in flight but its data belongs to a squashed path
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, req_pc;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic          push, pop, req_fire;

  assign imem_req    = (state == REQ);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = mem_data[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];

  // Next-state, fetch PC and occupancy; a redirect overrides everything else
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_fire     = 1'b0;
    push         = 1'b0;
    pop          = instr_valid && instr_ready && !redirect_valid;
    case (state)
      IDLE: if (count < DEPTH_C) state_nxt = REQ;
      REQ: if (imem_gnt) begin
        req_fire     = 1'b1;
        fetch_pc_nxt = fetch_pc + 32'd4;
        state_nxt    = WAIT;
      end
      WAIT: push = imem_rvalid && !redirect_valid;
      DROP: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    count_nxt = count + CW'(push) - CW'(pop);
    // only re-request while there is guaranteed room for the answer
    if (state == WAIT && imem_rvalid)
      state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
    if (redirect_valid) begin
      count_nxt    = '0;
      fetch_pc_nxt = redirect_pc & ~32'h3;
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     state_nxt = imem_gnt ? DROP : REQ;
        WAIT,
        DROP:    state_nxt = imem_rvalid ? REQ : DROP;
        default: state_nxt = REQ;
      endcase
    end
  end

  // Control state, fetch PC and the PC of the read in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (req_fire) req_pc <= fetch_pc;
    end
  end

  // FIFO storage and pointers; redirect rewinds both pointers to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else begin
      count <= count_nxt;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem_data[wr_ptr] <= imem_rdata;
          mem_pc[wr_ptr]   <= req_pc;
          wr_ptr           <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a small memory model answers
// mem[a] = a ^ 32'hA5A5_0000 with gnt in the request cycle and rvalid
// mem_lat cycles later.
module tb_instr_fetch_unit;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  int n_cmp = 0, n_err = 0;
  int mem_lat = 1;
  bit pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int lat_cnt = 0;
  int gnt_cnt = 0, rv_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  // memory model: one outstanding read, answers independent of core reset
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend) begin
      if (lat_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr ^ 32'hA5A5_0000;
        pend        = 1'b0;
      end else lat_cnt--;
    end
    imem_gnt = imem_req && !pend;
    if (imem_gnt) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      lat_cnt   = mem_lat;
    end
  end

  // transaction counters
  always @(posedge clk) begin
    if (imem_req && imem_gnt) gnt_cnt <= gnt_cnt + 1;
    if (imem_rvalid) rv_cnt <= rv_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    reset_n = 1'b0;
    cyc(3);
    reset_n = 1'b1;
  endtask

  // wait for a head, check it against the memory pattern, step past it if consumed
  task automatic wait_valid(input string tag, input logic [31:0] exp_pc, output int n);
    n = 0;
    while (!instr_valid && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"}, instr_pc, exp_pc);
    chk({tag, "_instr"}, instr, exp_pc ^ 32'hA5A5_0000);
    if (instr_ready) @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic wait_addr(input string tag, input logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 60) begin @(negedge clk); n++; end
    chk(tag, 32'(imem_req && imem_addr == a), 32'd1);
  endtask

  initial begin
    int n, g0, r0;
    @(negedge clk);

    // reset values, streaming with ready=1, first-valid latency
    mem_lat = 1; instr_ready = 1'b1;
    reset_n = 1'b0; cyc(3);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    reset_n = 1'b1;
    wait_valid("t1_w0", 32'h0, n);
    chk("t1_latency", 32'(n), 32'd3);
    wait_valid("t1_w1", 32'h4, n);
    wait_valid("t1_w2", 32'h8, n);
    wait_valid("t1_w3", 32'hC, n);

    // backpressure: fills exactly DEPTH, then stops requesting; drain in order
    instr_ready = 1'b0;
    do_reset();
    g0 = gnt_cnt;
    cyc(20);
    chk("t2_grants", 32'(gnt_cnt - g0), 32'd4);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_instr", instr, 32'hA5A5_0000);
    chk("t2_pc", instr_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_idle_req", 32'(imem_req), 32'd0);
      cyc(1);
    end
    instr_ready = 1'b1;
    wait_valid("t2_d0", 32'h0, n);
    wait_valid("t2_d1", 32'h4, n);
    wait_valid("t2_d2", 32'h8, n);
    wait_valid("t2_d3", 32'hC, n);
    wait_valid("t2_d4", 32'h10, n);

    // redirect while waiting on the read for 0x8 (rvalid still pending)
    mem_lat = 2;
    do_reset();
    wait_addr("t3_find8", 32'h8);
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t3_flush", 32'(instr_valid), 32'd0);
    chk("t3_drop_req", 32'(imem_req), 32'd0);
    wait_req("t3_next", 32'h100);
    wait_valid("t3_first", 32'h100, n);

    // redirect to unaligned target in the same cycle the request is granted
    mem_lat = 1;
    do_reset();
    wait_addr("t4_find4", 32'h4);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t4_drop_req", 32'(imem_req), 32'd0);
    chk("t4_target", imem_addr, 32'h200);
    wait_req("t4_next", 32'h200);
    wait_valid("t4_first", 32'h200, n);

    // redirect together with a pop while three entries are buffered
    instr_ready = 1'b0;
    do_reset();
    r0 = rv_cnt;
    n = 0;
    while ((rv_cnt - r0) < 3 && n < 60) begin @(negedge clk); n++; end
    chk("t5_fill3", 32'(rv_cnt - r0), 32'd3);
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(1);
    redirect_valid = 1'b0;
    chk("t5_flush", 32'(instr_valid), 32'd0);
    wait_valid("t5_first", 32'h40, n);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0;
    wait_valid("t6_top", 32'hFFFF_FFFC, n);
    wait_valid("t6_wrap", 32'h0, n);

    // reset pulsed during WAIT; the late rvalid must not be buffered
    mem_lat = 3;
    n = 0;
    while (!imem_req && n < 60) begin @(negedge clk); n++; end
    cyc(1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_req("t6_restart", 32'h0);
    cyc(1);
    chk("t6_stray", 32'(instr_valid), 32'd0);
    wait_valid("t6_after_rst", 32'h0, n);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
